// File: rtl/rx_gate_capture.sv
// Range-gated ADC capture: after each trigger, wait gate_delay cycles, sum gate_length
// offset-binary samples, and queue the signed sum in a small FWFT FIFO.
module rx_gate_capture #(
  parameter int unsigned ADC_WIDTH = 14,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 trigger,
  input  logic                 sample_strobe,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic [15:0]          gate_delay,
  input  logic [7:0]           gate_length,
  input  logic                 pop,
  input  logic                 clear_overflow,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 empty,
  output logic                 full,
  output logic [AW:0]          count,
  output logic                 data_ready,
  output logic                 busy,
  output logic                 overflow
);

  typedef enum logic [1:0] {StIdle, StDelay, StAccum, StStore} state_e;

  localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CntOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  state_e               r_state, w_state_d;
  logic [15:0]          r_dly, w_dly_d;
  logic [7:0]           r_len, w_len_d;
  logic [7:0]           r_cnt, w_cnt_d, w_cnt_inc;
  logic [ACC_WIDTH-1:0] r_acc, w_acc_d, w_sample;
  logic                 w_push;

  logic [ACC_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic [ACC_WIDTH-1:0] r_hold;
  logic                 r_ovf;
  logic                 w_do_push, w_do_pop;

  // Offset binary to two's complement: flip the MSB, then sign-extend.
  assign w_sample  = {{(ACC_WIDTH-ADC_WIDTH){~adc_data[ADC_WIDTH-1]}},
                      ~adc_data[ADC_WIDTH-1], adc_data[ADC_WIDTH-2:0]};
  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state_d = r_state;
    w_dly_d   = r_dly;
    w_len_d   = r_len;
    w_cnt_d   = r_cnt;
    w_acc_d   = r_acc;
    w_push    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (trigger) begin
          w_state_d = StDelay;
          w_dly_d   = gate_delay;
          w_len_d   = (gate_length == 8'd0) ? 8'd1 : gate_length;
        end
      end
      StDelay: begin
        if (r_dly == 16'd0) begin
          w_state_d = StAccum;
          w_acc_d   = '0;
          w_cnt_d   = 8'd0;
        end else begin
          w_dly_d = r_dly - 16'd1;
        end
      end
      StAccum: begin
        if (sample_strobe) begin
          w_acc_d = r_acc + w_sample;
          w_cnt_d = w_cnt_inc;
          if (w_cnt_inc == r_len) w_state_d = StStore;
        end
      end
      StStore: begin
        w_push    = 1'b1;
        w_state_d = StIdle;
      end
    endcase
    // Disable aborts any gate in flight, including its pending store.
    if (!enable) begin
      w_state_d = StIdle;
      w_push    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_dly   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_d;
      r_dly   <= w_dly_d;
      r_len   <= w_len_d;
      r_cnt   <= w_cnt_d;
      r_acc   <= w_acc_d;
    end
  end

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = w_push && (!full || w_do_pop);

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= r_acc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
        r_hold   <= r_mem[r_rd_ptr];
      end
      if (w_do_push && !w_do_pop)      r_count <= r_count + CntOne;
      else if (w_do_pop && !w_do_push) r_count <= r_count - CntOne;
      if (w_push && !w_do_push) r_ovf <= 1'b1;
      else if (clear_overflow)  r_ovf <= 1'b0;
    end
  end

  assign count      = r_count;
  assign empty      = (r_count == '0);
  assign full       = (r_count == CntFull);
  assign dout       = empty ? r_hold : r_mem[r_rd_ptr];
  assign busy       = (r_state != StIdle);
  assign data_ready = !empty && !busy;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_rx_gate_capture.sv
// Bench for rx_gate_capture: randomized gates checked against a transaction-level model
// (per-gate sum of converted samples, queue of expected FIFO words).
module tb_rx_gate_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        trigger;
  logic        sample_strobe;
  logic [13:0] adc_data;
  logic [15:0] gate_delay;
  logic [7:0]  gate_length;
  logic        pop;
  logic        clear_overflow;
  logic [23:0] dout;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        data_ready;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  int unsigned exp_q[$];
  int unsigned last_dout = 0;
  bit          exp_ovf = 1'b0;
  int unsigned g_data[256];

  rx_gate_capture dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .trigger       (trigger),
    .sample_strobe (sample_strobe),
    .adc_data      (adc_data),
    .gate_delay    (gate_delay),
    .gate_length   (gate_length),
    .pop           (pop),
    .clear_overflow(clear_overflow),
    .dout          (dout),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .data_ready    (data_ready),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_fifo(input string tag);
    int unsigned n;
    n = exp_q.size();
    check({tag, ".count"}, 32'(count), n);
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == 16));
    check({tag, ".dout"}, 32'(dout), (n > 0) ? exp_q[0] : last_dout);
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".data_ready"}, 32'(data_ready), 32'(n > 0));
  endtask

  task automatic model_pop();
    if (exp_q.size() > 0) last_dout = exp_q.pop_front();
  endtask

  task automatic pop_one(input string tag);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    model_pop();
    check_fifo(tag);
  endtask

  // One full gate using g_data[0..n-1]; retrig drives trigger high throughout the gate.
  task automatic run_gate(input int dly, input int len_raw, input int max_gap,
                          input bit pop_store, input bit retrig, input string tag);
    int n;
    int sum;
    int busy_cycles;
    int acc_cycles;
    n = (len_raw == 0) ? 1 : len_raw;
    sum = 0;
    busy_cycles = 0;
    acc_cycles = 0;
    gate_delay  = 16'(dly);
    gate_length = 8'(len_raw);
    trigger     = 1'b1;
    tick();
    for (int i = 0; i <= dly; i++) begin
      if (busy) busy_cycles++;
      sample_strobe = 1'($urandom_range(0, 1));
      adc_data      = 14'($urandom);
      gate_delay    = 16'($urandom);
      gate_length   = 8'($urandom);
      trigger       = retrig;
      tick();
    end
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        if (busy) busy_cycles++;
        sample_strobe = 1'b0;
        adc_data      = 14'($urandom);
        tick();
        acc_cycles++;
      end
      if (busy) busy_cycles++;
      sample_strobe = 1'b1;
      adc_data      = 14'(g_data[k]);
      sum += int'(g_data[k]) - 8192;
      tick();
      acc_cycles++;
    end
    if (busy) busy_cycles++;
    sample_strobe = 1'b0;
    trigger       = 1'b0;
    pop           = pop_store;
    tick();
    pop = 1'b0;
    check({tag, ".busy_len"}, 32'(busy_cycles), 32'(dly + 1 + acc_cycles + 1));
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    if (pop_store) model_pop();
    if (exp_q.size() < 16) exp_q.push_back(32'(sum) & 32'h00FF_FFFF);
    else exp_ovf = 1'b1;
    check_fifo(tag);
  endtask

  task automatic fill_rand(input int n);
    for (int k = 0; k < n; k++) g_data[k] = $urandom_range(0, 16383);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    trigger = 1'b0;
    sample_strobe = 1'b0;
    adc_data = '0;
    gate_delay = '0;
    gate_length = '0;
    pop = 1'b0;
    clear_overflow = 1'b0;
    #1;
    check_fifo("reset");
    check("reset.busy", 32'(busy), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset mid-ACCUM after 3 of 8 strobes
    gate_delay = 16'd2;
    gate_length = 8'd8;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      sample_strobe = 1'b1;
      adc_data = 14'($urandom);
      tick();
    end
    sample_strobe = 1'b0;
    check("midreset.busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset.busy", 32'(busy), 32'd0);
    check_fifo("midreset");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample_strobe = 1'($urandom_range(0, 1));
      tick();
    end
    sample_strobe = 1'b0;
    check("midreset.busy_post", 32'(busy), 32'd0);
    check_fifo("midreset_post");

    // Basic gate
    for (int k = 0; k < 4; k++) g_data[k] = 32'h2005;
    run_gate(10, 4, 0, 1'b0, 1'b0, "basic");
    check("basic.dout_const", 32'(dout), 32'h14);
    pop_one("basic_pop");

    // Sign conversion
    g_data[0] = 32'h0000;
    g_data[1] = 32'h3FFF;
    run_gate(3, 2, 1, 1'b0, 1'b1, "sign");
    check("sign.dout_const", 32'(dout), 32'hFF_FFFF);
    pop_one("sign_pop");

    // Zero parameters, with trigger held high through the gate
    g_data[0] = 32'h2001;
    run_gate(0, 0, 0, 1'b0, 1'b1, "zero");
    check("zero.dout_const", 32'(dout), 32'h1);
    pop_one("zero_pop");

    // Fill, overflow, push+pop while full, clear
    for (int g = 0; g < 16; g++) begin
      fill_rand(3);
      run_gate($urandom_range(0, 4), 3, 1, 1'b0, 1'b0, "fill");
    end
    check("fill.full", 32'(full), 32'd1);
    fill_rand(2);
    run_gate(1, 2, 0, 1'b0, 1'b0, "ovf17");
    fill_rand(2);
    run_gate(1, 2, 0, 1'b1, 1'b0, "ovf18");
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    exp_ovf = 1'b0;
    check_fifo("clear_ovf");

    // Enable dropped mid-ACCUM
    gate_delay = 16'd1;
    gate_length = 8'd8;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      sample_strobe = 1'b1;
      adc_data = 14'($urandom);
      tick();
    end
    sample_strobe = 1'b0;
    enable = 1'b0;
    tick();
    check("endrop.busy", 32'(busy), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample_strobe = 1'($urandom_range(0, 1));
      tick();
    end
    sample_strobe = 1'b0;
    check_fifo("endrop");
    for (int i = 0; i < 16; i++) pop_one("drain");
    pop_one("pop_empty");

    // Randomized gates with interleaved pops and clears
    for (int g = 0; g < 30; g++) begin
      int len;
      len = $urandom_range(0, 10);
      fill_rand(len == 0 ? 1 : len);
      run_gate($urandom_range(0, 15), len, 2, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0) pop_one("rand_pop");
      if ($urandom_range(0, 7) == 0) begin
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        check_fifo("rand_clear");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
